// File: rtl/call_return_ctrl.sv
// Call/return sequencer: pushes return addresses, redirects the PC and traps
// on stack overflow/underflow. All outputs decode from registered state.
module call_return_ctrl #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         call_req,
  input  logic         ret_req,
  input  logic [W-1:0] pc_plus1,
  input  logic [W-1:0] call_target,
  input  logic         stack_overflow,
  input  logic [W-1:0] stack_pop_data,
  output logic         push_sig,
  output logic         pop_sig,
  output logic [W-1:0] push_data,
  output logic         pc_load,
  output logic [W-1:0] pc_next,
  output logic         stall,
  output logic         trap_overflow,
  output logic         trap_underflow,
  output logic [3:0]   depth
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    JUMP,
    POP,
    RET_LOAD,
    TRAP
  } state_t;

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

  state_t       state, state_nxt;
  logic [W-1:0] ret_addr, tgt_addr;
  logic [3:0]   depth_q;
  logic         ovf_q, unf_q;
  logic         latch_en, set_ovf, set_unf;

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    unique case (state)
      IDLE: begin
        if (call_req) begin
          if (depth_q < DEPTH_MAX) begin
            state_nxt = PUSH;
            latch_en  = 1'b1;
          end else begin
            state_nxt = TRAP;
            set_ovf   = 1'b1;
          end
        end else if (ret_req) begin
          if (depth_q != '0) begin
            state_nxt = POP;
          end else begin
            state_nxt = TRAP;
            set_unf   = 1'b1;
          end
        end
      end
      PUSH:     state_nxt = JUMP;
      JUMP:     state_nxt = IDLE;
      POP:      state_nxt = RET_LOAD;
      RET_LOAD: state_nxt = IDLE;
      TRAP:     state_nxt = TRAP;
      default:  state_nxt = IDLE;
    endcase
    // An overflow from the stack overrides whatever the sequencer was doing
    if (stack_overflow) begin
      state_nxt = TRAP;
      set_ovf   = 1'b1;
      latch_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ret_addr <= '0;
      tgt_addr <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        ret_addr <= pc_plus1;
        tgt_addr <= call_target;
      end
      // The strobe was issued this cycle, so the count follows it on exit
      if (state == PUSH && depth_q < DEPTH_MAX) depth_q <= depth_q + 4'd1;
      if (state == POP && depth_q != '0)        depth_q <= depth_q - 4'd1;
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  always_comb begin
    push_sig       = (state == PUSH);
    pop_sig        = (state == POP);
    push_data      = push_sig ? ret_addr : '0;
    pc_load        = (state == JUMP) || (state == RET_LOAD);
    pc_next        = '0;
    if (state == JUMP)     pc_next = tgt_addr;
    if (state == RET_LOAD) pc_next = stack_pop_data;
    stall          = (state != IDLE);
    trap_overflow  = ovf_q;
    trap_underflow = unf_q;
    depth          = depth_q;
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: directed scenarios plus random traffic checked
// against a queue-of-pending-cycles model with a software return stack.
module tb_call_return_ctrl;
  localparam int W     = 12;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         call_req, ret_req, stack_overflow;
  logic [W-1:0] pc_plus1, call_target, stack_pop_data;
  logic         push_sig, pop_sig, pc_load, stall, trap_overflow, trap_underflow;
  logic [W-1:0] push_data, pc_next;
  logic [3:0]   depth;

  call_return_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_req(ret_req),
    .pc_plus1(pc_plus1), .call_target(call_target),
    .stack_overflow(stack_overflow), .stack_pop_data(stack_pop_data),
    .push_sig(push_sig), .pop_sig(pop_sig), .push_data(push_data),
    .pc_load(pc_load), .pc_next(pc_next), .stall(stall),
    .trap_overflow(trap_overflow), .trap_underflow(trap_underflow),
    .depth(depth)
  );

  always #5 clk = ~clk;

  // One entry per busy cycle the controller still owes after an accepted request
  typedef struct {
    bit           push;
    bit           pop;
    bit           load;
    bit           from_pop;
    logic [W-1:0] data;
    int           dd;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] stk[$];
  bit           m_trap, m_ovf, m_unf;
  int           m_depth;
  logic [W-1:0] m_retval;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    stk.delete();
    m_trap = 0; m_ovf = 0; m_unf = 0; m_depth = 0; m_retval = '0;
  endtask

  task automatic check_all();
    bit           e_push, e_pop, e_load;
    logic [W-1:0] e_pdata, e_pcn;
    e_push = 0; e_pop = 0; e_load = 0; e_pdata = '0; e_pcn = '0;
    if (!m_trap && q.size() > 0) begin
      e_push = q[0].push;
      e_pop  = q[0].pop;
      e_load = q[0].load;
      if (e_push) e_pdata = q[0].data;
      if (e_load) e_pcn = q[0].from_pop ? m_retval : q[0].data;
    end
    chk("push_sig", 32'(push_sig), 32'(e_push));
    chk("pop_sig", 32'(pop_sig), 32'(e_pop));
    chk("push_data", 32'(push_data), 32'(e_pdata));
    chk("pc_load", 32'(pc_load), 32'(e_load));
    chk("pc_next", 32'(pc_next), 32'(e_pcn));
    chk("stall", 32'(stall), 32'(m_trap || q.size() > 0));
    chk("trap_overflow", 32'(trap_overflow), 32'(m_ovf));
    chk("trap_underflow", 32'(trap_underflow), 32'(m_unf));
    chk("depth", 32'(depth), 32'(m_depth));
  endtask

  task automatic model_step(input bit c, input bit r, input bit o,
                            input logic [W-1:0] p, input logic [W-1:0] t);
    ent_t cur;
    bit   had = 0;
    if (!m_trap && q.size() > 0) begin
      cur = q.pop_front();
      had = 1;
      m_depth += cur.dd;
    end
    if (o) begin
      m_trap = 1; m_ovf = 1; q.delete();
    end else if (!m_trap && !had) begin
      if (c) begin
        if (m_depth == DEPTH) begin
          m_trap = 1; m_ovf = 1;
        end else begin
          q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, p, 1});
          q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, t, 0});
          stk.push_back(p);
        end
      end else if (r) begin
        if (m_depth == 0) begin
          m_trap = 1; m_unf = 1;
        end else begin
          m_retval = (stk.size() > 0) ? stk.pop_back() : W'($urandom);
          stack_pop_data = m_retval;
          q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, '0, -1});
          q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, '0, 0});
        end
      end
    end
  endtask

  task automatic step(input bit c, input bit r, input bit o,
                      input logic [W-1:0] p, input logic [W-1:0] t);
    call_req = c; ret_req = r; stack_overflow = o; pc_plus1 = p; call_target = t;
    model_step(c, r, o, p, t);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    call_req = 0; ret_req = 0; stack_overflow = 0;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit c, r, o;
    rst_n = 1'b0; call_req = 0; ret_req = 0; stack_overflow = 0;
    pc_plus1 = '0; call_target = '0; stack_pop_data = '0;
    @(negedge clk);
    do_reset();

    // Single call then return
    step(1, 0, 0, 12'h005, 12'h100);
    chk("c1_push_data", 32'(push_data), 32'h005);
    step(0, 0, 0, '0, '0);
    chk("c1_pc_next", 32'(pc_next), 32'h100);
    step(0, 0, 0, '0, '0);
    chk("c1_depth", 32'(depth), 32'd1);
    step(0, 1, 0, '0, '0);
    chk("r1_pop", 32'(pop_sig), 32'd1);
    step(0, 0, 0, '0, '0);
    chk("r1_pc_next", 32'(pc_next), 32'h005);
    step(0, 0, 0, '0, '0);
    chk("r1_stall", 32'(stall), 32'd0);
    chk("r1_depth", 32'(depth), 32'd0);

    // Fill the stack, then overflow with a ninth call
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, W'(i + 1), W'(12'h200 + i));
      step(0, 0, 0, '0, '0);
      step(0, 0, 0, '0, '0);
    end
    chk("full_depth", 32'(depth), 32'd8);
    step(1, 0, 0, 12'h0AA, 12'h0BB);
    chk("ovf_no_push", 32'(push_sig), 32'd0);
    chk("ovf_trap", 32'(trap_overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, '0);
    chk("ovf_stall_held", 32'(stall), 32'd1);

    // Return on an empty stack
    do_reset();
    step(0, 1, 0, '0, '0);
    chk("unf_no_pop", 32'(pop_sig), 32'd0);
    chk("unf_trap", 32'(trap_underflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 12'h001, 12'h002);
    chk("unf_stall_held", 32'(stall), 32'd1);
    do_reset();
    chk("unf_cleared", 32'(stall), 32'd0);

    // Simultaneous call and return: call wins, return during PUSH ignored
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, W'(i + 8), W'(i + 16));
      step(0, 0, 0, '0, '0);
      step(0, 0, 0, '0, '0);
    end
    step(1, 1, 0, 12'h033, 12'h044);
    chk("both_push", 32'(push_sig), 32'd1);
    step(0, 1, 0, '0, '0);
    chk("both_depth", 32'(depth), 32'd4);
    step(0, 0, 0, '0, '0);

    // Stack overflow input from IDLE
    step(0, 0, 1, '0, '0);
    chk("sovf_trap", 32'(trap_overflow), 32'd1);

    // Asynchronous reset during POP
    do_reset();
    step(1, 0, 0, 12'h011, 12'h022);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    chk("pre_rst_pop", 32'(pop_sig), 32'd1);
    #2;
    rst_n = 1'b0;
    call_req = 0; ret_req = 0; stack_overflow = 0;
    model_clear();
    #1;
    chk("rst_pop_drop", 32'(pop_sig), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 12'h005, 12'h100);
    chk("post_rst_push_data", 32'(push_data), 32'h005);
    step(0, 0, 0, '0, '0);
    chk("post_rst_pc_next", 32'(pc_next), 32'h100);
    chk("post_rst_depth", 32'(depth), 32'd1);

    // Random traffic
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(0, 149) == 0 || (m_trap && $urandom_range(0, 19) == 0)) begin
          do_reset();
        end else begin
          c = (m_depth == DEPTH) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
          r = (m_depth == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
          o = ($urandom_range(0, 299) == 0);
          step(c, r, o, W'($urandom), W'($urandom));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
